run_sched: RTL and testbench
============================

RUN_SCHED -- requirements
Module: run_sched

Interface
REQ-001 Parameter: ITER_W, 24, width of run_times, remaining-iteration counter and iter_count.
REQ-002 Constant: node_num, from replica_pkg, number of replica nodes.
REQ-003 S_AXI_ACLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 S_AXI_ARESETN  input  1  asynchronous active-low reset.
REQ-005 run_write  input  1  one-cycle start command from the bus interface.
REQ-006 run_times  input  ITER_W  iteration count; sampled only when run_write is accepted.
REQ-007 running  output  1  high while a run is in progress.
REQ-008 opt_run  output  1  one-cycle pulse that starts the optimisation phase on all nodes.
REQ-009 opt_done  input  node_num  per-node one-cycle completion pulses.
REQ-010 exchange_run  output  1  one-cycle pulse that starts the replica-exchange phase.
REQ-011 exchange_odd  output  1  pair parity for the current exchange: 0 = even pairs, 1 = odd pairs.
REQ-012 exchange_done  input  1  one-cycle exchange completion pulse.
REQ-013 iter_count  output  ITER_W  iterations completed in the current or last run.
REQ-014 stop_req  input  1  graceful-stop pulse; port is present only with RUN_STOP_EN.

Function
REQ-015 The FSM SHALL have the states IDLE, OPT_START, OPT_WAIT, EXC_START and EXC_WAIT.
REQ-016 In IDLE, run_write with run_times != 0 SHALL move to OPT_START, load remaining = run_times, clear iter_count and clear exchange_odd.
REQ-017 run_write with run_times == 0 SHALL be ignored, and run_write outside IDLE SHALL be ignored.
REQ-018 running SHALL equal (state != IDLE) as a registered output, so it rises the cycle after an accepted run_write.
REQ-019 opt_run SHALL be high exactly during the OPT_START cycle; done_mask SHALL clear in that cycle, and opt_done in OPT_START SHALL be ignored.
REQ-020 OPT_START SHALL always go to OPT_WAIT.
REQ-021 In OPT_WAIT, done_mask SHALL OR in opt_done every cycle.
REQ-022 OPT_WAIT SHALL move to EXC_START in the cycle that (done_mask | opt_done) is all ones, including when several bits arrive simultaneously.
REQ-023 exchange_run SHALL be high exactly during the EXC_START cycle; EXC_START SHALL always go to EXC_WAIT.
REQ-024 In EXC_WAIT, exchange_done SHALL increment iter_count, decrement remaining and toggle exchange_odd.
REQ-025 On that same exchange_done, the FSM SHALL go to IDLE if remaining was 1, otherwise to OPT_START.
REQ-026 opt_done outside OPT_WAIT and exchange_done outside EXC_WAIT SHALL be ignored; duplicate opt_done pulses from a node SHALL have no further effect.
REQ-027 iter_count SHALL hold its value in IDLE until the next accepted run_write.
REQ-028 No counter SHALL wrap: remaining never decrements below 1 in EXC_WAIT, and iter_count <= run_times.

Reset
REQ-029 ARESETN low SHALL immediately force state = IDLE and set running, opt_run, exchange_run, exchange_odd, iter_count, remaining and done_mask to 0, including mid-run.
REQ-030 After reset release, the block SHALL wait for a fresh run_write; an interrupted run SHALL NOT resume.

Configuration
REQ-031 With RUN_STOP_EN defined, stop_req in any non-IDLE state SHALL set a stop flag; the next exchange_done SHALL then end the run in IDLE regardless of remaining, and the flag SHALL clear on entry to IDLE.
REQ-032 With RUN_STOP_EN defined, stop_req in IDLE SHALL be ignored.
REQ-033 Without RUN_STOP_EN, the stop_req port and stop flag SHALL NOT exist, and runs end only when remaining is exhausted.

Verification
REQ-034 run_write with run_times=3, all nodes done 5 cycles after each opt_run, exchange_done 2 cycles after each exchange_run -> exactly 3 opt_run and 3 exchange_run pulses, exchange_odd 0,1,0, iter_count=3, running falls the cycle after the third exchange_done.
REQ-035 run_write with run_times=0 -> running stays 0, no pulses; a second run_write mid-run -> ignored, iter_count unaffected.
REQ-036 opt_done bits arriving staggered, one node repeated, one in the OPT_START cycle -> exchange_run occurs only after every node pulses in OPT_WAIT.
REQ-037 Reset asserted in OPT_WAIT of iteration 2 of 5 -> all outputs 0 asynchronously; new run_write with run_times=1 -> one clean iteration.
REQ-038 RUN_STOP_EN defined, run_times=10, stop_req during iteration 2 -> run ends after exchange_done of iteration 2 with iter_count=2; undefined build -> iter_count=10.

Source files
------------

// File: rtl/run_sched_if.sv
// Replica constants and run scheduler bus: start command, phase pulses, completions.
// Macro RUN_STOP_EN adds stop_req. Modports: master drives commands, slave is the scheduler.
package replica_pkg;
  localparam int node_num = 4;
endpackage

interface run_sched_if #(
  parameter int ITER_W = 24
);
  import replica_pkg::*;

  logic                run_write;
  logic [ITER_W-1:0]   run_times;
  logic                running;
  logic                opt_run;
  logic [node_num-1:0] opt_done;
  logic                exchange_run;
  logic                exchange_odd;
  logic                exchange_done;
  logic [ITER_W-1:0]   iter_count;
`ifdef RUN_STOP_EN
  logic                stop_req;

  modport master (
    output run_write, run_times,
    output opt_done, exchange_done,
    output stop_req,
    input  running, opt_run,
    input  exchange_run, exchange_odd,
    input  iter_count
  );

  modport slave (
    input  run_write, run_times,
    input  opt_done, exchange_done,
    input  stop_req,
    output running, opt_run,
    output exchange_run, exchange_odd,
    output iter_count
  );
`else
  modport master (
    output run_write, run_times,
    output opt_done, exchange_done,
    input  running, opt_run,
    input  exchange_run, exchange_odd,
    input  iter_count
  );

  modport slave (
    input  run_write, run_times,
    input  opt_done, exchange_done,
    output running, opt_run,
    output exchange_run, exchange_odd,
    output iter_count
  );
`endif
endinterface

// File: rtl/run_sched.sv
// Replica run scheduler: iterates optimise / exchange phases run_times times.
// Ports: S_AXI_ACLK, S_AXI_ARESETN, bus (run_sched_if.slave). Macro RUN_STOP_EN: graceful stop.
module run_sched #(
  parameter int ITER_W = 24
) (
  input logic       S_AXI_ACLK,
  input logic       S_AXI_ARESETN,
  run_sched_if.slave bus
);
  import replica_pkg::*;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] OPT_START = 3'd1;
  localparam logic [2:0] OPT_WAIT  = 3'd2;
  localparam logic [2:0] EXC_START = 3'd3;
  localparam logic [2:0] EXC_WAIT  = 3'd4;

  logic [2:0]          state;
  logic [ITER_W-1:0]   remaining;
  logic [ITER_W-1:0]   iter_q;
  logic [node_num-1:0] done_mask;
  logic [node_num-1:0] mask_nxt;
  logic                odd_q;
  logic                last;
  logic                exc_end;

  assign mask_nxt = done_mask | bus.opt_done;
  assign exc_end  = (state == EXC_WAIT) && bus.exchange_done;

`ifdef RUN_STOP_EN
  logic stop_q;

  assign last = (remaining == ITER_W'(1)) || stop_q;

  // A stop raised on the final exchange_done is dropped: the run ends anyway.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      stop_q <= 1'b0;
    end else if (exc_end && last) begin
      stop_q <= 1'b0;
    end else if (state != IDLE && bus.stop_req) begin
      stop_q <= 1'b1;
    end
  end
`else
  assign last = (remaining == ITER_W'(1));
`endif

  assign bus.running      = (state != IDLE);
  assign bus.opt_run      = (state == OPT_START);
  assign bus.exchange_run = (state == EXC_START);
  assign bus.exchange_odd = odd_q;
  assign bus.iter_count   = iter_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state     <= IDLE;
      remaining <= '0;
      iter_q    <= '0;
      done_mask <= '0;
      odd_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.run_write && bus.run_times != '0) begin
            state     <= OPT_START;
            remaining <= bus.run_times;
            iter_q    <= '0;
            odd_q     <= 1'b0;
          end
        end
        OPT_START: begin
          done_mask <= '0;
          state     <= OPT_WAIT;
        end
        OPT_WAIT: begin
          done_mask <= mask_nxt;
          if (&mask_nxt) begin
            state <= EXC_START;
          end
        end
        EXC_START: begin
          state <= EXC_WAIT;
        end
        EXC_WAIT: begin
          if (bus.exchange_done) begin
            iter_q <= iter_q + ITER_W'(1);
            odd_q  <= ~odd_q;
            // Held at 1 on the final pass so it can never wrap.
            if (remaining > ITER_W'(1)) begin
              remaining <= remaining - ITER_W'(1);
            end
            state <= last ? IDLE : OPT_START;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_run_sched.sv
// Self-checking bench for run_sched: vector table, hand sequences, random runs.
// Builds with or without RUN_STOP_EN.
module tb_run_sched;
  import replica_pkg::*;

  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  run_sched_if #(.ITER_W(W)) bus();

  run_sched #(.ITER_W(W)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .bus          (bus)
  );

  logic [node_num-1:0] a_od = '0;
  logic [node_num-1:0] m_od = '0;
  logic                a_xd = 1'b0;
  logic                m_xd = 1'b0;
  assign bus.opt_done      = a_od | m_od;
  assign bus.exchange_done = a_xd | m_xd;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Auto responder: node completions and exchange completion.
  bit auto_en = 1'b1;
  bit rnd_nodes = 1'b0;
  int opt_dly = 5;
  int exc_dly = 2;
  int exp_exc_cyc = -1;

  initial begin
    tick();
    forever begin
      if (auto_en && bus.opt_run) begin
        int d[node_num];
        int mx;
        mx = 0;
        for (int i = 0; i < node_num; i++) begin
          d[i] = rnd_nodes ? int'($urandom_range(1, 6)) : opt_dly;
          if (d[i] > mx) mx = d[i];
        end
        exp_exc_cyc = cyc + mx + 1;
        for (int k = 1; k <= mx; k++) begin
          tick();
          for (int i = 0; i < node_num; i++) a_od[i] = (d[i] == k);
        end
        tick();
        a_od = '0;
      end else if (auto_en && bus.exchange_run) begin
        repeat (exc_dly) tick();
        a_xd = 1'b1;
        tick();
        a_xd = 1'b0;
      end else begin
        tick();
      end
    end
  end

  // Monitor: pulse counts, parity log, fall timing.
  int n_opt = 0;
  int n_exc = 0;
  bit odd_log[$];
  int last_xd = -10;
  int fall_cyc = -10;
  bit prev_run = 1'b0;

  always @(negedge clk) begin
    if (bus.opt_run) n_opt++;
    if (bus.exchange_run) begin
      n_exc++;
      odd_log.push_back(bus.exchange_odd);
      if (auto_en && exp_exc_cyc >= 0) chk("exc_timing", cyc, exp_exc_cyc);
    end
    if (bus.exchange_done && bus.running) last_xd = cyc;
    if (prev_run && !bus.running) fall_cyc = cyc;
    prev_run = bus.running;
  end

  task automatic run_cmd(input int n);
    bus.run_times = W'(n);
    bus.run_write = 1'b1;
    tick();
    bus.run_write = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (bus.running && k < 3000) begin
      tick();
      k++;
    end
    chk({nm, "_timeout"}, bus.running, 0);
  endtask

  task automatic wait_opt(input int target);
    int k;
    k = 0;
    while (n_opt < target && k < 500) begin
      tick();
      k++;
    end
    chk("opt_wait", n_opt >= target, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_running"}, bus.running, 0);
    chk({nm, "_opt_run"}, bus.opt_run, 0);
    chk({nm, "_exc_run"}, bus.exchange_run, 0);
    chk({nm, "_odd"}, bus.exchange_odd, 0);
    chk({nm, "_iter"}, bus.iter_count, 0);
  endtask

  // Checks one finished run against the rule: n pulses, parity 0,1,0...
  task automatic chk_run(input string nm, input int pulses, input int cnt,
                         input int o0, input int e0);
    chk({nm, "_iter"}, bus.iter_count, cnt);
    chk({nm, "_nopt"}, n_opt - o0, pulses);
    chk({nm, "_nexc"}, n_exc - e0, pulses);
    for (int i = 0; i < odd_log.size(); i++)
      chk({nm, "_odd"}, odd_log[i], i % 2);
    if (pulses != 0) chk({nm, "_fall"}, fall_cyc - last_xd, 1);
  endtask

  typedef struct {
    int times;
    int od;
    int xd;
    bit mid_write;
    int exp_pulses;
    int exp_cnt;
  } vec_t;

  vec_t vt[5];
  int o0;
  int e0;
  int model_cnt;

  initial begin
    bus.run_write = 1'b0;
    bus.run_times = '0;
`ifdef RUN_STOP_EN
    bus.stop_req = 1'b0;
`endif
    vt[0] = '{3, 5, 2, 1'b0, 3, 3};
    vt[1] = '{1, 1, 1, 1'b0, 1, 1};
    vt[2] = '{2, 3, 4, 1'b1, 2, 2};
    vt[3] = '{0, 2, 2, 1'b0, 0, 2};
    vt[4] = '{4, 2, 1, 1'b0, 4, 4};

    #12;
    chk_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      opt_dly = vt[v].od;
      exc_dly = vt[v].xd;
      o0 = n_opt;
      e0 = n_exc;
      odd_log.delete();
      run_cmd(vt[v].times);
      chk("vec_rise", bus.running, vt[v].exp_pulses != 0);
      if (vt[v].mid_write) begin
        repeat (3) tick();
        run_cmd(7);
      end
      wait_idle("vec");
      repeat (5) tick();
      chk_run("vec", vt[v].exp_pulses, vt[v].exp_cnt, o0, e0);
    end

    // Staggered completions driven by hand.
    auto_en = 1'b0;
    exp_exc_cyc = -1;
    run_cmd(1);
    chk("stag_optrun", bus.opt_run, 1);
    m_od = 1;
    tick();
    m_od = '0;
    m_xd = 1'b1;
    tick();
    m_xd = 1'b0;
    for (int i = 1; i < node_num; i++) begin
      m_od = '0;
      m_od[i] = 1'b1;
      tick();
      chk("stag_early", bus.exchange_run, 0);
      if (i == 1) begin
        tick();
        chk("stag_dup", bus.exchange_run, 0);
      end
    end
    m_od = '0;
    repeat (2) tick();
    chk("stag_wait", bus.exchange_run, 0);
    m_od = 1;
    tick();
    m_od = '0;
    chk("stag_exc", bus.exchange_run, 1);
    chk("stag_iter0", bus.iter_count, 0);
    m_xd = 1'b1;
    tick();
    m_xd = 1'b0;
    chk("stag_excstart_ign", bus.iter_count, 0);
    chk("stag_busy", bus.running, 1);
    m_xd = 1'b1;
    tick();
    m_xd = 1'b0;
    chk("stag_done", bus.running, 0);
    chk("stag_iter1", bus.iter_count, 1);
    auto_en = 1'b1;

    // Reset in OPT_WAIT of iteration 2 of 5.
    opt_dly = 5;
    exc_dly = 2;
    o0 = n_opt;
    run_cmd(5);
    wait_opt(o0 + 2);
    repeat (2) tick();
    chk("rst_pre_iter", bus.iter_count, 1);
    chk("rst_pre_odd", bus.exchange_odd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    tick();
    tick();
    rst_n = 1'b1;
    o0 = n_opt;
    repeat (8) tick();
    chk("rst_no_resume", bus.running, 0);
    chk("rst_no_opt", n_opt - o0, 0);
    e0 = n_exc;
    odd_log.delete();
    run_cmd(1);
    wait_idle("rst_run");
    repeat (3) tick();
    chk_run("rst_run", 1, 1, o0, e0);

`ifdef RUN_STOP_EN
    opt_dly = 2;
    exc_dly = 1;
    bus.stop_req = 1'b1;
    tick();
    bus.stop_req = 1'b0;
    o0 = n_opt;
    e0 = n_exc;
    odd_log.delete();
    run_cmd(3);
    wait_idle("stop_idle");
    repeat (3) tick();
    chk_run("stop_idle", 3, 3, o0, e0);
    o0 = n_opt;
    e0 = n_exc;
    odd_log.delete();
    run_cmd(10);
    wait_opt(o0 + 2);
    bus.stop_req = 1'b1;
    tick();
    bus.stop_req = 1'b0;
    wait_idle("stop");
    repeat (3) tick();
    chk_run("stop", 2, 2, o0, e0);
`else
    opt_dly = 2;
    exc_dly = 1;
    o0 = n_opt;
    e0 = n_exc;
    odd_log.delete();
    run_cmd(10);
    wait_idle("full10");
    repeat (3) tick();
    chk_run("full10", 10, 10, o0, e0);
`endif

    // Random runs against the counting model.
    rnd_nodes = 1'b1;
    model_cnt = int'(bus.iter_count);
    for (int r = 0; r < 20; r++) begin
      int t;
      t = int'($urandom_range(0, 6));
      exc_dly = int'($urandom_range(1, 4));
      o0 = n_opt;
      e0 = n_exc;
      odd_log.delete();
      run_cmd(t);
      if (t != 0 && $urandom_range(0, 1) == 1) begin
        repeat (int'($urandom_range(1, 6))) tick();
        run_cmd(int'($urandom_range(0, 9)));
      end
      wait_idle("rnd");
      repeat (3) tick();
      if (t != 0) model_cnt = t;
      chk_run("rnd", t, model_cnt, o0, e0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end
endmodule
